sr_drive_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the SR flip-flop and drives its s/r inputs. It accepts one-cycle set/clear/toggle requests and converts each into a clean s or r pulse of fixed width, followed by a guard gap. It guarantees that s=r=1 is never presented. It checks the flip-flop's q feedback after each operation and buffers one request that arrives while busy.

---
 rtl/sr_drive_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sr_drive_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_drive_ctrl.sv
// Purpose: turns one-cycle set/clear/toggle requests into a clean s or r pulse followed by a guard gap, then checks q feedback.
// Latency: a request sampled at edge N drives s/r during cycle N+1; a pended request launches on the edge after the gap ends.
// Backpressure: there is no ready signal; one request is buffered while busy, and any further request is dropped with drop_err.
module sr_drive_ctrl #(
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic tog_req,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic verify_err,
    output logic conflict_err,
    output logic drop_err
);

    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SET = 2'd0,
        OP_CLR = 2'd1,
        OP_TOG = 2'd2
    } op_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          tgt, tgt_n;
    logic          pend_vld, pend_vld_n;
    op_t           pend_op, pend_op_n;

    logic s_n, r_n, busy_n, done_n, verify_n, conflict_n, drop_n;

    logic [1:0] req_cnt;
    logic       req_vld;
    logic       req_conf;
    op_t        req_op;

    logic       launch;
    op_t        launch_op;
    logic       launch_tgt;
    logic       direct_take;

    always_comb begin
        req_cnt  = 2'(set_req) + 2'(clr_req) + 2'(tog_req);
        req_vld  = (req_cnt == 2'd1);
        req_conf = (req_cnt >= 2'd2);
        if (set_req)      req_op = OP_SET;
        else if (clr_req) req_op = OP_CLR;
        else              req_op = OP_TOG;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        tgt_n      = tgt;
        pend_vld_n = pend_vld;
        pend_op_n  = pend_op;
        s_n        = 1'b0;
        r_n        = 1'b0;
        done_n     = 1'b0;
        verify_n   = 1'b0;
        drop_n     = 1'b0;
        launch     = 1'b0;
        launch_op  = req_op;
        launch_tgt = 1'b0;
        direct_take = 1'b0;

        case (state)
            IDLE: begin
                // The pending slot wins over a fresh request arriving on the same edge.
                if (pend_vld) begin
                    launch     = 1'b1;
                    launch_op  = pend_op;
                    pend_vld_n = 1'b0;
                end else if (req_vld) begin
                    launch      = 1'b1;
                    direct_take = 1'b1;
                end
            end
            DRIVE: begin
                s_n = tgt;
                r_n = ~tgt;
                if (cnt == PULSE_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                    s_n     = 1'b0;
                    r_n     = 1'b0;
                    done_n  = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) verify_n = (q_fb != tgt);
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        if (launch) begin
            case (launch_op)
                OP_SET:  launch_tgt = 1'b1;
                OP_CLR:  launch_tgt = 1'b0;
                default: launch_tgt = ~q_fb;
            endcase
            state_n = DRIVE;
            cnt_n   = '0;
            tgt_n   = launch_tgt;
            s_n     = launch_tgt;
            r_n     = ~launch_tgt;
        end

        if (req_vld && !direct_take) begin
            if (!pend_vld_n) begin
                pend_vld_n = 1'b1;
                pend_op_n  = req_op;
            end else begin
                drop_n = 1'b1;
            end
        end

        // Masking with the current output keeps every flag a strict one-cycle pulse.
        done_n     = done_n   & ~done;
        verify_n   = verify_n & ~verify_err;
        drop_n     = drop_n   & ~drop_err;
        conflict_n = req_conf & ~conflict_err;
        busy_n     = (state_n != IDLE) || pend_vld_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tgt          <= 1'b0;
            pend_vld     <= 1'b0;
            pend_op      <= OP_SET;
            s            <= 1'b0;
            r            <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            verify_err   <= 1'b0;
            conflict_err <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            tgt          <= tgt_n;
            pend_vld     <= pend_vld_n;
            pend_op      <= pend_op_n;
            s            <= s_n;
            r            <= r_n;
            busy         <= busy_n;
            done         <= done_n;
            verify_err   <= verify_n;
            conflict_err <= conflict_n;
            drop_err     <= drop_n;
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Scoreboard bench for sr_drive_ctrl with PULSE_CYC=3, GAP_CYC=2 and a behavioural SR flip-flop on q_fb.
// An op launched at edge L shows s/r in cycles L..L+2, done in L+3 and verify_err (if any) in L+4.
`timescale 1ns/1ps
module tb_sr_drive_ctrl;

    localparam int P = 3;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0, clr_req = 1'b0, tog_req = 1'b0;
    logic q_fb;
    logic s, r, busy, done, verify_err, conflict_err, drop_err;

    logic q_mdl = 1'b0;
    logic stuck_en = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    typedef struct packed {
        logic busy, s, r, done, verr, cerr, derr;
    } ov_t;

    typedef struct {
        int  cyc;
        ov_t v;
    } exp_t;

    exp_t sb[$];
    ov_t  mon_act;

    sr_drive_ctrl #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk(clk), .rst(rst),
        .set_req(set_req), .clr_req(clr_req), .tog_req(tog_req),
        .q_fb(q_fb),
        .s(s), .r(r), .busy(busy), .done(done),
        .verify_err(verify_err), .conflict_err(conflict_err), .drop_err(drop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (s)      q_mdl <= 1'b1;
        else if (r) q_mdl <= 1'b0;
    end
    assign q_fb = stuck_en ? 1'b0 : q_mdl;

    function automatic ov_t mk(input logic b, sv, rv, dn, ve, ce, de);
        ov_t v;
        v = {b, sv, rv, dn, ve, ce, de};
        return v;
    endfunction

    // Sorted insert; expectations landing in the same cycle merge into one record.
    function automatic void push(input int c, input ov_t v);
        exp_t e;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == c) begin
                e = sb[i];
                e.v = e.v | v;
                sb[i] = e;
                return;
            end
            if (sb[i].cyc > c) begin
                e.cyc = c;
                e.v = v;
                sb.insert(i, e);
                return;
            end
        end
        e.cyc = c;
        e.v = v;
        sb.push_back(e);
    endfunction

    function automatic void push_op(input int l, input logic tgt, input logic verr);
        for (int i = 0; i < P; i++) push(l + i, mk(1'b1, tgt, ~tgt, 1'b0, 1'b0, 1'b0, 1'b0));
        push(l + P, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        if (verr) push(l + P + 1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    endfunction

    always @(negedge clk) begin
        mon_act = {busy, s, r, done, verify_err, conflict_err, drop_err};
        if (s && r) begin
            n_fail++;
            $display("FAIL s_r_both cycle %0d: s=%b r=%b, required never both high", cyc, s, r);
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missed_event cycle %0d: nothing seen, required %b", sb[0].cyc, sb[0].v);
            void'(sb.pop_front());
        end
        if (mon_act.s | mon_act.r | mon_act.done | mon_act.verr | mon_act.cerr | mon_act.derr) begin
            n_cmp++;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                if (mon_act !== sb[0].v) begin
                    n_fail++;
                    $display("FAIL event cycle %0d: got {busy,s,r,done,verr,cerr,derr}=%b, required %b",
                             cyc, mon_act, sb[0].v);
                end
                void'(sb.pop_front());
            end else begin
                n_fail++;
                $display("FAIL unexpected_event cycle %0d: got %b, required no activity", cyc, mon_act);
            end
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missing_event cycle %0d: got %b, required %b", cyc, mon_act, sb[0].v);
            void'(sb.pop_front());
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_req(input int c, input logic sv, input logic cv, input logic tv);
        wait_cyc(c);
        set_req = sv;
        clr_req = cv;
        tog_req = tv;
        @(negedge clk);
        set_req = 1'b0;
        clr_req = 1'b0;
        tog_req = 1'b0;
    endtask

    task automatic check_busy(input int c, input logic exp_b);
        wait_cyc(c);
        n_cmp++;
        if (busy !== exp_b) begin
            n_fail++;
            $display("FAIL busy cycle %0d: got %b, required %b", cyc, busy, exp_b);
        end
    endtask

    task automatic check_quiet(input string name);
        ov_t a;
        a = {busy, s, r, done, verify_err, conflict_err, drop_err};
        n_cmp++;
        if (a !== '0) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, required 0000000", name, cyc, a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        wait_cyc(1);
        check_quiet("reset_state");
        rst = 1'b0;

        // Single set: launch edge 3, done 6, idle at 8.
        push_op(3, 1'b1, 1'b0);
        pulse_req(2, 1'b1, 1'b0, 1'b0);
        check_busy(8, 1'b0);

        // Clear then toggle back to back: toggle waits in the slot, targets ~q_fb=1 at edge 17.
        push_op(11, 1'b0, 1'b0);
        push_op(17, 1'b1, 1'b0);
        pulse_req(10, 1'b0, 1'b1, 1'b0);
        pulse_req(11, 1'b0, 1'b0, 1'b1);
        check_busy(16, 1'b1);
        check_busy(22, 1'b0);

        // Two-bit and three-bit conflicts are discarded.
        push(25, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        pulse_req(24, 1'b1, 1'b1, 1'b0);
        push(27, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        pulse_req(26, 1'b1, 1'b1, 1'b1);
        check_busy(28, 1'b0);

        // set/clr/tog in 30..32: clr pended, tog dropped; a tog at 36 refills the slot as clr leaves it.
        push_op(31, 1'b1, 1'b0);
        push(33, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        push_op(37, 1'b0, 1'b0);
        push_op(43, 1'b1, 1'b0);
        pulse_req(30, 1'b1, 1'b0, 1'b0);
        pulse_req(31, 1'b0, 1'b1, 1'b0);
        pulse_req(32, 1'b0, 1'b0, 1'b1);
        pulse_req(36, 1'b0, 1'b0, 1'b1);
        check_busy(42, 1'b1);
        check_busy(48, 1'b0);

        // q_fb stuck at 0 under a set: verify_err one cycle after the first gap cycle.
        wait_cyc(49);
        stuck_en = 1'b1;
        push_op(51, 1'b1, 1'b1);
        pulse_req(50, 1'b1, 1'b0, 1'b0);
        wait_cyc(57);
        stuck_en = 1'b0;

        // Redundant set while q is already 1.
        push_op(59, 1'b1, 1'b0);
        pulse_req(58, 1'b1, 1'b0, 1'b0);
        check_busy(64, 1'b0);

        // Reset during the second drive cycle with the slot full.
        push(67, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        push(68, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        pulse_req(66, 1'b0, 1'b1, 1'b0);
        pulse_req(67, 1'b1, 1'b0, 1'b0);
        wait_cyc(68);
        rst = 1'b1;
        wait_cyc(69);
        check_quiet("mid_pulse_reset");
        rst = 1'b0;

        push_op(72, 1'b1, 1'b0);
        pulse_req(71, 1'b0, 1'b0, 1'b1);
        check_busy(77, 1'b0);

        wait_cyc(80);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: got %0d unmatched, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
